// File: rtl/burst_pkg.sv
// burst_pkg: shared types and defaults for the burst tracker.
//   state_e          - tracker FSM state (IDLE, ACTIVE, DONE)
//   DEFAULT_CNT_W    - default beat counter / length width
//   DEFAULT_TO_LIMIT - default watchdog idle-cycle limit
//   idle_cnt_width() - width of a counter that must hold 0 .. limit-1
package burst_pkg;

    localparam int unsigned DEFAULT_CNT_W    = 8;
    localparam int unsigned DEFAULT_TO_LIMIT = 1023;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    function automatic int unsigned idle_cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/burst_tracker_if.sv
// burst_tracker_if: beat handshake and status bundle of the burst tracker.
//   i_start, i_len        - burst request and length-minus-one
//   i_valid, i_ready      - beat handshake
//   o_busy, o_count       - ACTIVE flag and beats counted so far
//   o_last, o_done        - final-beat indicator and completion pulse
//   o_timeout             - sticky watchdog flag
// Modports: master drives requests/beats, slave is the tracker.
interface burst_tracker_if
    import burst_pkg::*;
#(
    parameter int unsigned CNT_W = DEFAULT_CNT_W
);

    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             i_valid;
    logic             i_ready;
    logic             o_busy;
    logic [CNT_W-1:0] o_count;
    logic             o_last;
    logic             o_done;
    logic             o_timeout;

    modport master (
        output i_start, i_len, i_valid, i_ready,
        input  o_busy, o_count, o_last, o_done, o_timeout
    );

    modport slave (
        input  i_start, i_len, i_valid, i_ready,
        output o_busy, o_count, o_last, o_done, o_timeout
    );

endinterface

// File: rtl/burst_watchdog.sv
// burst_watchdog: counts consecutive tick cycles and flags when TO_LIMIT is reached.
// Only compiled when BURST_TIMEOUT_EN is defined.
//   clk     - clock
//   arst    - asynchronous active-high reset
//   clear   - restart the idle count (has priority over tick)
//   tick    - one idle cycle elapsed
//   expired - high in the cycle whose tick is the TO_LIMIT-th in a row
`ifdef BURST_TIMEOUT_EN
module burst_watchdog
    import burst_pkg::*;
#(
    parameter int unsigned TO_LIMIT = DEFAULT_TO_LIMIT
) (
    input  logic clk,
    input  logic arst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = idle_cnt_width(TO_LIMIT);
    localparam logic [W-1:0] LastIdle = W'(TO_LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Counter holds ticks already seen, so the limit is hit on the tick after LastIdle.
    assign expired = tick & ~clear & (cnt_q == LastIdle);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/burst_tracker.sv
// burst_tracker: tracks one AXI-style burst of i_len+1 beats at a time.
//   clk      - clock
//   arst     - asynchronous active-high reset
//   restartn - synchronous active-low abort
//   bus      - burst_tracker_if.slave (request, beat handshake, status outputs)
// Optional feature: define BURST_TIMEOUT_EN to add an idle watchdog that abandons a
// burst after TO_LIMIT consecutive beat-less ACTIVE cycles and sets o_timeout.
module burst_tracker
    import burst_pkg::*;
#(
    parameter int unsigned CNT_W    = DEFAULT_CNT_W,
    parameter int unsigned TO_LIMIT = DEFAULT_TO_LIMIT
) (
    input  logic           clk,
    input  logic           arst,
    input  logic           restartn,
    burst_tracker_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             beat;
    logic             last;

    assign beat = (state_q == ACTIVE) & bus.i_valid & bus.i_ready;
    assign last = (state_q == ACTIVE) & (count_q == len_q);

`ifdef BURST_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wd_clear, wd_tick, wd_expired;

    assign wd_tick  = (state_q == ACTIVE) & ~beat;
    assign wd_clear = (state_q != ACTIVE) | beat | ~restartn;

    burst_watchdog #(
        .TO_LIMIT (TO_LIMIT)
    ) u_watchdog (
        .clk     (clk),
        .arst    (arst),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );
`else
    logic unused_to_limit;
    assign unused_to_limit = ^TO_LIMIT;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        done_d  = 1'b0;
`ifdef BURST_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            // DONE accepts a new request exactly like IDLE, giving back-to-back bursts.
            IDLE, DONE: begin
                if (bus.i_start) begin
                    state_d = ACTIVE;
                    len_d   = bus.i_len;
                    count_d = '0;
`ifdef BURST_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (beat) begin
                    // Final beat leaves count at len, so a full-range burst never wraps.
                    if (last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
`ifdef BURST_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (!restartn) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
`ifdef BURST_TIMEOUT_EN
            timeout_d = 1'b0;
`endif
        end

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef BURST_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef BURST_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_count = count_q;
    assign bus.o_last  = last;
    assign bus.o_done  = done_q;
`ifdef BURST_TIMEOUT_EN
    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_burst_tracker.sv
// tb_burst_tracker: self-checking bench for burst_tracker.
// Two instances: CNT_W = 8 (main) and CNT_W = 4 (boundary), both with TO_LIMIT = 8.
module tb_burst_tracker;
    import burst_pkg::*;

    localparam int unsigned TO_LIM = 8;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic restartn = 1'b1;
    int   checks = 0;
    int   errors = 0;

    burst_tracker_if #(.CNT_W(8)) bus8 ();
    burst_tracker_if #(.CNT_W(4)) bus4 ();

    burst_tracker #(.CNT_W(8), .TO_LIMIT(TO_LIM)) dut8 (
        .clk      (clk),
        .arst     (arst),
        .restartn (restartn),
        .bus      (bus8.slave)
    );

    burst_tracker #(.CNT_W(4), .TO_LIMIT(TO_LIM)) dut4 (
        .clk      (clk),
        .arst     (arst),
        .restartn (restartn),
        .bus      (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive8(input bit st, input int len, input bit v, input bit r);
        bus8.i_start = st;
        bus8.i_len   = 8'(len);
        bus8.i_valid = v;
        bus8.i_ready = r;
    endtask

    task automatic drive4(input bit st, input int len, input bit v, input bit r);
        bus4.i_start = st;
        bus4.i_len   = 4'(len);
        bus4.i_valid = v;
        bus4.i_ready = r;
    endtask

    // Behavioural model: a burst is "busy" until len+1 beats are taken; the count
    // shown is beats taken, capped at len because the final beat is not added.
    bit m_busy, m_done, m_to;
    int m_beats, m_len, m_idle;

    function automatic void model_step(input bit st, input int len, input bit v, input bit r,
                                       input bit rn);
        if (!rn) begin
            m_busy = 0; m_beats = 0; m_done = 0; m_to = 0; m_idle = 0;
        end else if (m_busy) begin
            m_done = 0;
            if (v && r) begin
                m_idle = 0;
                if (m_beats == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_beats = m_beats + 1;
                end
            end else begin
                m_idle = m_idle + 1;
`ifdef BURST_TIMEOUT_EN
                if (m_idle == int'(TO_LIM)) begin
                    m_busy = 0; m_to = 1; m_idle = 0;
                end
`endif
            end
        end else begin
            m_done = 0;
            if (st) begin
                m_busy = 1; m_len = len; m_beats = 0; m_to = 0; m_idle = 0;
            end
        end
    endfunction

    typedef struct {
        bit st; int len; bit v; bit r; bit rn;
        bit busy; int cnt; bit last; bit done;
    } vec_t;

    function automatic vec_t mk(input bit st, input int len, input bit v, input bit r,
                                input bit rn, input bit busy, input int cnt, input bit last,
                                input bit done);
        vec_t x;
        x.st = st; x.len = len; x.v = v; x.r = r; x.rn = rn;
        x.busy = busy; x.cnt = cnt; x.last = last; x.done = done;
        return x;
    endfunction

    initial begin
        vec_t tbl[$];
        drive8(0, 0, 0, 0);
        drive4(0, 0, 0, 0);

        // Asynchronous reset before any clock edge
        #1 arst = 1'b1;
        #2;
        chk("rst_busy", 32'(bus8.o_busy), 0);
        chk("rst_count", 32'(bus8.o_count), 0);
        chk("rst_last", 32'(bus8.o_last), 0);
        chk("rst_done", 32'(bus8.o_done), 0);
        chk("rst_timeout", 32'(bus8.o_timeout), 0);
        repeat (2) @(posedge clk);
        #2 arst = 1'b0;

        //            st len v r rn | busy cnt last done
        // basic burst, len 3
        tbl.push_back(mk(1, 3, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 3, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0));
        // back-pressure, len 1, plus an ignored start while ACTIVE
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 0, 0));
        // back-to-back single-beat bursts, restart from the DONE cycle
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
        // abort after 2 of 8 beats with start and a beat in the same cycle
        tbl.push_back(mk(1, 7, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 1, 2, 0, 0));
        tbl.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive8(tbl[i].st, tbl[i].len, tbl[i].v, tbl[i].r);
            restartn = tbl[i].rn;
            cyc();
            chk($sformatf("vec%0d_busy", i), 32'(bus8.o_busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_count", i), 32'(bus8.o_count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_last", i), 32'(bus8.o_last), 32'(tbl[i].last));
            chk($sformatf("vec%0d_done", i), 32'(bus8.o_done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_timeout", i), 32'(bus8.o_timeout), 0);
        end
        restartn = 1'b1;

        // Asynchronous reset mid-burst, then no resume
        drive8(1, 7, 0, 0);
        cyc();
        drive8(0, 0, 1, 1);
        repeat (3) cyc();
        chk("arst_pre_count", 32'(bus8.o_count), 3);
        arst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus8.o_busy), 0);
        chk("arst_count", 32'(bus8.o_count), 0);
        chk("arst_last", 32'(bus8.o_last), 0);
        chk("arst_done", 32'(bus8.o_done), 0);
        #1 arst = 1'b0;
        cyc();
        chk("arst_noresume_busy", 32'(bus8.o_busy), 0);
        chk("arst_noresume_count", 32'(bus8.o_count), 0);
        drive8(0, 0, 0, 0);

        // CNT_W = 4 full-length burst
        drive4(1, 15, 0, 0);
        cyc();
        chk("w4_start_busy", 32'(bus4.o_busy), 1);
        drive4(0, 0, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k <= 15) begin
                chk($sformatf("w4_beat%0d_count", k), 32'(bus4.o_count), 32'(k));
                chk($sformatf("w4_beat%0d_last", k), 32'(bus4.o_last), 32'(k == 15));
                chk($sformatf("w4_beat%0d_done", k), 32'(bus4.o_done), 0);
            end else begin
                chk("w4_end_busy", 32'(bus4.o_busy), 0);
                chk("w4_end_count", 32'(bus4.o_count), 15);
                chk("w4_end_done", 32'(bus4.o_done), 1);
            end
        end
        drive4(0, 0, 0, 0);
        cyc();
        chk("w4_done_once", 32'(bus4.o_done), 0);
        chk("w4_hold_count", 32'(bus4.o_count), 15);

        // CNT_W = 8 full-length burst
        drive8(1, 255, 0, 0);
        cyc();
        drive8(0, 0, 1, 1);
        repeat (255) cyc();
        chk("w8_max_count", 32'(bus8.o_count), 255);
        chk("w8_max_last", 32'(bus8.o_last), 1);
        cyc();
        chk("w8_max_done", 32'(bus8.o_done), 1);
        chk("w8_max_hold", 32'(bus8.o_count), 255);
        drive8(0, 0, 0, 0);
        cyc();

        // Watchdog
        drive8(1, 3, 0, 0);
        cyc();
        drive8(0, 0, 1, 1);
        cyc();
        chk("to_beat_count", 32'(bus8.o_count), 1);
        drive8(0, 0, 0, 0);
`ifdef BURST_TIMEOUT_EN
        repeat (TO_LIM - 1) cyc();
        chk("to_pre_busy", 32'(bus8.o_busy), 1);
        chk("to_pre_flag", 32'(bus8.o_timeout), 0);
        cyc();
        chk("to_busy", 32'(bus8.o_busy), 0);
        chk("to_flag", 32'(bus8.o_timeout), 1);
        chk("to_no_done", 32'(bus8.o_done), 0);
        repeat (3) cyc();
        chk("to_sticky", 32'(bus8.o_timeout), 1);
        drive8(1, 0, 0, 0);
        cyc();
        chk("to_clear_flag", 32'(bus8.o_timeout), 0);
        chk("to_clear_busy", 32'(bus8.o_busy), 1);
`else
        repeat (3 * TO_LIM) cyc();
        chk("nto_busy", 32'(bus8.o_busy), 1);
        chk("nto_flag", 32'(bus8.o_timeout), 0);
`endif

        // Randomized run against the model, from a clean abort
        drive8(0, 0, 0, 0);
        restartn = 1'b0;
        cyc();
        restartn = 1'b1;
        m_busy = 0; m_beats = 0; m_done = 0; m_to = 0; m_idle = 0; m_len = 0;
        for (int n = 0; n < 3000; n++) begin
            bit st, v, r, rn;
            int len;
            st  = ($urandom_range(0, 3) == 0);
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                              : int'($urandom_range(0, 6));
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 3) != 0);
            rn  = ($urandom_range(0, 63) != 0);
            drive8(st, len, v, r);
            restartn = rn;
            model_step(st, len, v, r, rn);
            cyc();
            chk("rnd_busy", 32'(bus8.o_busy), 32'(m_busy));
            chk("rnd_count", 32'(bus8.o_count), 32'(m_beats));
            chk("rnd_last", 32'(bus8.o_last), 32'(m_busy && (m_beats == m_len)));
            chk("rnd_done", 32'(bus8.o_done), 32'(m_done));
            chk("rnd_timeout", 32'(bus8.o_timeout), 32'(m_to));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
